// File: rtl/quad_enc_multi.sv
// ----------------------------------------------------------------------------
// quad_enc_multi
//
// Multi-channel quadrature encoder front end with a shared pushbutton.
// Every raw input (enc_a, enc_b, btn_n) goes through a 2-flop synchronizer and
// a debouncer. It then feeds either a per-channel step/direction decoder with
// an up/down position counter, or the short/long press classifier.
//
// Ports
//   clk        : single clock, all state on the rising edge
//   rst_n      : synchronous active-low reset
//   ena        : 1 = counting and event pulses enabled
//   enc_a/b    : raw quadrature inputs, one bit per channel, asynchronous
//   btn_n      : raw pushbutton, active-low, asynchronous
//   mode       : 00 = x1, 01 = x2, 10/11 = x4 resolution
//   wrap       : 1 = counters wrap, 0 = counters saturate
//   clr        : synchronous clear of all counts and error flags
//   count      : channel i position at [i*CNT_W +: CNT_W], unsigned
//   step       : one-cycle pulse per counted step
//   dir        : direction of the last counted step (1 = CW)
//   err        : sticky illegal-transition flag
//   btn_short  : pulse on release of a short press
//   btn_long   : pulse when a press reaches LONG_CYC cycles
// ----------------------------------------------------------------------------
module quad_enc_multi #(
    parameter int unsigned N_CH     = 2,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned DEB_CYC  = 4,
    parameter int unsigned LONG_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [N_CH-1:0]       enc_a,
    input  logic [N_CH-1:0]       enc_b,
    input  logic                  btn_n,
    input  logic [1:0]            mode,
    input  logic                  wrap,
    input  logic                  clr,
    output logic [N_CH*CNT_W-1:0] count,
    output logic [N_CH-1:0]       step,
    output logic [N_CH-1:0]       dir,
    output logic [N_CH-1:0]       err,
    output logic                  btn_short,
    output logic                  btn_long
);

    // All raw inputs share one sync/debounce path: {btn_n, enc_b, enc_a}.
    localparam int unsigned NSig = 2 * N_CH + 1;
    localparam int unsigned DebW = $clog2(DEB_CYC + 1);
    localparam int unsigned TmrW = $clog2(LONG_CYC + 1);
    localparam logic [NSig-1:0] RstLvl  = {1'b1, {(2 * N_CH){1'b0}}};
    localparam logic [DebW-1:0] DebLast = DebW'(DEB_CYC - 1);
    localparam logic [TmrW-1:0] TmrLast = TmrW'(LONG_CYC - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPressed,
        StLong
    } btn_st_e;

    // ------------------------------------------------------------------
    // Synchronizer and debouncer
    // ------------------------------------------------------------------
    logic [NSig-1:0] raw;
    logic [NSig-1:0] sync1_q;
    logic [NSig-1:0] sync2_q;
    logic [NSig-1:0] deb_q;
    logic [NSig-1:0] deb_d;
    logic [DebW-1:0] deb_cnt_q [NSig];
    logic [DebW-1:0] deb_cnt_d [NSig];

    assign raw = {btn_n, enc_b, enc_a};

    // The counter tracks how many consecutive cycles the synchronized level
    // has disagreed with the debounced one; agreement restarts it.
    always_comb begin
        deb_d = deb_q;
        for (int unsigned i = 0; i < NSig; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DebLast) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DebW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Quadrature decode
    // ------------------------------------------------------------------
    logic [N_CH-1:0] cur_a;
    logic [N_CH-1:0] cur_b;
    logic [N_CH-1:0] prev_a_q;
    logic [N_CH-1:0] prev_b_q;
    logic [N_CH-1:0] mv_cw;
    logic [N_CH-1:0] mv_ccw;
    logic [N_CH-1:0] mv_bad;
    logic [N_CH-1:0] mv_hit;

    assign cur_a = deb_q[N_CH-1:0];
    assign cur_b = deb_q[2*N_CH-1:N_CH];

    // Transitions keyed as {prev_a, prev_b, cur_a, cur_b}.
    always_comb begin
        mv_cw  = '0;
        mv_ccw = '0;
        mv_bad = '0;
        mv_hit = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            case ({prev_a_q[i], prev_b_q[i], cur_a[i], cur_b[i]})
                4'b0010, 4'b1011, 4'b1101, 4'b0100: mv_cw[i]  = 1'b1;
                4'b0001, 4'b0111, 4'b1110, 4'b1000: mv_ccw[i] = 1'b1;
                4'b0011, 4'b1100, 4'b1001, 4'b0110: mv_bad[i] = 1'b1;
                default: ;
            endcase
            // Resolution filter looks only at the destination state.
            case (mode)
                2'b00:   mv_hit[i] = ~cur_a[i] & ~cur_b[i];
                2'b01:   mv_hit[i] = (cur_a[i] == cur_b[i]);
                default: mv_hit[i] = 1'b1;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Counters, step/dir/err
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [N_CH-1:0]  step_q;
    logic [N_CH-1:0]  step_d;
    logic [N_CH-1:0]  dir_q;
    logic [N_CH-1:0]  dir_d;
    logic [N_CH-1:0]  err_q;
    logic [N_CH-1:0]  err_d;

    always_comb begin
        step_d = '0;
        dir_d  = dir_q;
        err_d  = err_q;
        for (int unsigned i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr) begin
                cnt_d[i] = '0;
                err_d[i] = 1'b0;
            end else begin
                if (mv_bad[i]) begin
                    err_d[i] = 1'b1;
                end
                // A counted step pulses and sets dir even when saturation
                // holds the count still.
                if (ena && mv_hit[i] && (mv_cw[i] || mv_ccw[i])) begin
                    step_d[i] = 1'b1;
                    dir_d[i]  = mv_cw[i];
                    if (mv_cw[i]) begin
                        if (wrap || (cnt_q[i] != {CNT_W{1'b1}})) begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end else begin
                        if (wrap || (cnt_q[i] != '0)) begin
                            cnt_d[i] = cnt_q[i] - CNT_W'(1);
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Button press classifier
    // ------------------------------------------------------------------
    btn_st_e         btn_st_q;
    btn_st_e         btn_st_d;
    logic [TmrW-1:0] tmr_q;
    logic [TmrW-1:0] tmr_d;
    logic            btn_short_q;
    logic            btn_short_d;
    logic            btn_long_q;
    logic            btn_long_d;
    logic            btn_pressed;

    assign btn_pressed = ~deb_q[NSig-1];

    always_comb begin
        btn_st_d    = btn_st_q;
        tmr_d       = tmr_q;
        btn_short_d = 1'b0;
        btn_long_d  = 1'b0;
        unique case (btn_st_q)
            StIdle: begin
                if (btn_pressed) begin
                    btn_st_d = StPressed;
                    tmr_d    = '0;
                end
            end
            StPressed: begin
                if (!btn_pressed) begin
                    btn_st_d    = StIdle;
                    btn_short_d = ena;
                end else if (ena) begin
                    tmr_d = tmr_q + TmrW'(1);
                    if (tmr_q == TmrLast) begin
                        btn_st_d   = StLong;
                        btn_long_d = 1'b1;
                    end
                end
            end
            StLong: begin
                if (!btn_pressed) begin
                    btn_st_d = StIdle;
                end
            end
            default: btn_st_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q     <= RstLvl;
            sync2_q     <= RstLvl;
            deb_q       <= RstLvl;
            for (int unsigned i = 0; i < NSig; i++) begin
                deb_cnt_q[i] <= '0;
            end
            prev_a_q    <= '0;
            prev_b_q    <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
            step_q      <= '0;
            dir_q       <= '0;
            err_q       <= '0;
            btn_st_q    <= StIdle;
            tmr_q       <= '0;
            btn_short_q <= 1'b0;
            btn_long_q  <= 1'b0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            deb_cnt_q   <= deb_cnt_d;
            // Previous state always follows, so nothing is owed on re-enable.
            prev_a_q    <= cur_a;
            prev_b_q    <= cur_b;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            dir_q       <= dir_d;
            err_q       <= err_d;
            btn_st_q    <= btn_st_d;
            tmr_q       <= tmr_d;
            btn_short_q <= btn_short_d;
            btn_long_q  <= btn_long_d;
        end
    end

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            count[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    assign step      = step_q;
    assign dir       = dir_q;
    assign err       = err_q;
    assign btn_short = btn_short_q;
    assign btn_long  = btn_long_q;

endmodule

// File: tb/tb_quad_enc_multi.sv
// ----------------------------------------------------------------------------
// tb_quad_enc_multi
//
// Directed bench for quad_enc_multi with default parameters. A reference
// model advances on every rising edge and all outputs are compared with it
// 1 ns later; literal checks at key points pin the expected behaviour.
// ----------------------------------------------------------------------------
module tb_quad_enc_multi;

    localparam int N_CH     = 2;
    localparam int CNT_W    = 8;
    localparam int DEB_CYC  = 4;
    localparam int LONG_CYC = 16;
    localparam int CMAX     = 255;

    logic                  clk;
    logic                  rst_n;
    logic                  ena;
    logic [N_CH-1:0]       enc_a;
    logic [N_CH-1:0]       enc_b;
    logic                  btn_n;
    logic [1:0]            mode;
    logic                  wrap;
    logic                  clr;
    logic [N_CH*CNT_W-1:0] count;
    logic [N_CH-1:0]       step;
    logic [N_CH-1:0]       dir;
    logic [N_CH-1:0]       err;
    logic                  btn_short;
    logic                  btn_long;

    quad_enc_multi #(
        .N_CH     (N_CH),
        .CNT_W    (CNT_W),
        .DEB_CYC  (DEB_CYC),
        .LONG_CYC (LONG_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .btn_n     (btn_n),
        .mode      (mode),
        .wrap      (wrap),
        .clr       (clr),
        .count     (count),
        .step      (step),
        .dir       (dir),
        .err       (err),
        .btn_short (btn_short),
        .btn_long  (btn_long)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Raw sample history, newest first; index k holds the sample from k+1 edges back.
    logic [4:0] m_hist [0:DEB_CYC];
    logic [4:0] m_deb;
    logic [1:0] m_pa, m_pb;
    int         m_cnt [N_CH];
    logic [1:0] m_step, m_dir, m_err;
    logic       m_held, m_long_done, m_short, m_long;
    int         m_hold;
    int         stp_tot [N_CH];
    int         short_tot = 0;
    int         long_tot  = 0;

    // Position around the CW cycle 00 -> 10 -> 11 -> 01.
    function automatic int gidx(input logic a, input logic b);
        case ({a, b})
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_update();
        logic [4:0] old_deb;
        logic       na, nb, cnt_ok, all_diff, pressed;
        int         d;
        if (!rst_n) begin
            for (int k = 0; k <= DEB_CYC; k++) m_hist[k] = 5'b10000;
            m_deb = 5'b10000;
            m_pa = '0; m_pb = '0;
            for (int c = 0; c < N_CH; c++) m_cnt[c] = 0;
            m_step = '0; m_dir = '0; m_err = '0;
            m_held = 1'b0; m_long_done = 1'b0; m_hold = 0;
            m_short = 1'b0; m_long = 1'b0;
        end else begin
            old_deb = m_deb;
            for (int c = 0; c < N_CH; c++) begin
                na = old_deb[c];
                nb = old_deb[2+c];
                d  = (gidx(na, nb) - gidx(m_pa[c], m_pb[c]) + 4) % 4;
                if (mode == 2'b00)      cnt_ok = (!na && !nb);
                else if (mode == 2'b01) cnt_ok = (na == nb);
                else                    cnt_ok = 1'b1;
                m_step[c] = 1'b0;
                if (clr) begin
                    m_cnt[c] = 0;
                    m_err[c] = 1'b0;
                end else begin
                    if (d == 2) m_err[c] = 1'b1;
                    if ((d == 1 || d == 3) && cnt_ok && ena) begin
                        m_step[c] = 1'b1;
                        m_dir[c]  = (d == 1);
                        if (d == 1) begin
                            if (wrap)                m_cnt[c] = (m_cnt[c] + 1) % (CMAX + 1);
                            else if (m_cnt[c] < CMAX) m_cnt[c] = m_cnt[c] + 1;
                        end else begin
                            if (wrap)              m_cnt[c] = (m_cnt[c] + CMAX) % (CMAX + 1);
                            else if (m_cnt[c] > 0) m_cnt[c] = m_cnt[c] - 1;
                        end
                    end
                end
                m_pa[c] = na;
                m_pb[c] = nb;
            end
            // Press length in enabled cycles decides short vs long.
            pressed = !old_deb[4];
            m_short = 1'b0;
            m_long  = 1'b0;
            if (!m_held) begin
                if (pressed) begin
                    m_held = 1'b1; m_hold = 0; m_long_done = 1'b0;
                end
            end else if (!pressed) begin
                if (!m_long_done && ena) m_short = 1'b1;
                m_held = 1'b0;
            end else if (!m_long_done && ena) begin
                m_hold++;
                if (m_hold == LONG_CYC) begin
                    m_long = 1'b1; m_long_done = 1'b1;
                end
            end
            // A level is accepted once the last DEB_CYC synchronized samples all disagree.
            for (int s = 0; s < 5; s++) begin
                all_diff = 1'b1;
                for (int k = 1; k <= DEB_CYC; k++) begin
                    if (m_hist[k][s] == m_deb[s]) all_diff = 1'b0;
                end
                if (all_diff) m_deb[s] = ~m_deb[s];
            end
            for (int k = DEB_CYC; k >= 1; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = {btn_n, enc_b, enc_a};
        end
    endtask

    initial begin
        logic [15:0] exp_count;
        stp_tot[0] = 0;
        stp_tot[1] = 0;
        forever begin
            @(posedge clk);
            model_update();
            #1;
            exp_count = {8'(m_cnt[1]), 8'(m_cnt[0])};
            check("mdl_count", 32'(count), 32'(exp_count));
            check("mdl_step", 32'(step), 32'(m_step));
            check("mdl_dir", 32'(dir), 32'(m_dir));
            check("mdl_err", 32'(err), 32'(m_err));
            check("mdl_btn_short", 32'(btn_short), 32'(m_short));
            check("mdl_btn_long", 32'(btn_long), 32'(m_long));
            for (int c = 0; c < N_CH; c++) if (step[c] === 1'b1) stp_tot[c]++;
            if (btn_short === 1'b1) short_tot++;
            if (btn_long === 1'b1) long_tot++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic lvl(input int c, input logic a, input logic b, input int n);
        enc_a[c] = a;
        enc_b[c] = b;
        hold(n);
    endtask

    initial begin
        int s0, s1, sh, lg;
        rst_n = 1'b0; ena = 1'b1; enc_a = '0; enc_b = '0; btn_n = 1'b1;
        mode = 2'b10; wrap = 1'b0; clr = 1'b0;
        hold(3);
        check("rst_count", 32'(count), 0);
        check("rst_step", 32'(step), 0);
        check("rst_dir", 32'(dir), 0);
        check("rst_err", 32'(err), 0);
        check("rst_btn", 32'({btn_short, btn_long}), 0);
        rst_n = 1'b1;
        hold(2);

        // One full CW cycle on ch0 at x4, with exact latency on the first edge.
        s0 = stp_tot[0];
        enc_a[0] = 1'b1;
        repeat (6) @(posedge clk);
        #1 check("lat_before", 32'(count[7:0]), 0);
        @(posedge clk);
        #1 check("lat_count", 32'(count[7:0]), 1);
        check("lat_step", 32'(step[0]), 1);
        @(negedge clk);
        hold(2);
        lvl(0, 1'b1, 1'b1, 10);
        lvl(0, 1'b0, 1'b1, 10);
        lvl(0, 1'b0, 1'b0, 10);
        check("cw_x4_count0", 32'(count[7:0]), 4);
        check("cw_x4_dir0", 32'(dir[0]), 1);
        check("cw_x4_count1", 32'(count[15:8]), 0);
        check("cw_x4_steps", 32'(stp_tot[0] - s0), 4);

        // x1 CW cycle then x2 CCW cycle.
        mode = 2'b00;
        lvl(0, 1'b1, 1'b0, 10); lvl(0, 1'b1, 1'b1, 10);
        lvl(0, 1'b0, 1'b1, 10); lvl(0, 1'b0, 1'b0, 10);
        check("cw_x1_count0", 32'(count[7:0]), 5);
        mode = 2'b01;
        lvl(0, 1'b0, 1'b1, 10); lvl(0, 1'b1, 1'b1, 10);
        lvl(0, 1'b1, 1'b0, 10); lvl(0, 1'b0, 1'b0, 10);
        check("ccw_x2_count0", 32'(count[7:0]), 3);
        check("ccw_x2_dir0", 32'(dir[0]), 0);
        clr = 1'b1;
        hold(1);
        clr = 1'b0;
        check("clr_count", 32'(count), 0);
        s0 = stp_tot[0];
        lvl(0, 1'b0, 1'b1, 10); lvl(0, 1'b1, 1'b1, 10);
        lvl(0, 1'b1, 1'b0, 10); lvl(0, 1'b0, 1'b0, 10);
        check("sat0_count0", 32'(count[7:0]), 0);
        check("sat0_dir0", 32'(dir[0]), 0);
        check("sat0_steps", 32'(stp_tot[0] - s0), 2);

        // Wrap and saturation at the top, then a short glitch.
        mode = 2'b10;
        wrap = 1'b1;
        lvl(0, 1'b0, 1'b1, 10);
        check("wrap_down", 32'(count[7:0]), 255);
        wrap = 1'b0;
        lvl(0, 1'b0, 1'b0, 10);
        check("sat_top", 32'(count[7:0]), 255);
        check("sat_top_dir", 32'(dir[0]), 1);
        wrap = 1'b1;
        lvl(0, 1'b1, 1'b0, 10);
        check("wrap_up", 32'(count[7:0]), 0);
        lvl(0, 1'b0, 1'b0, 10);
        check("wrap_down2", 32'(count[7:0]), 255);
        s0 = stp_tot[0];
        enc_a[0] = 1'b1;
        hold(3);
        enc_a[0] = 1'b0;
        hold(12);
        check("glitch_count", 32'(count[7:0]), 255);
        check("glitch_steps", 32'(stp_tot[0] - s0), 0);

        // Illegal double change on ch1, then clear.
        wrap = 1'b0;
        lvl(1, 1'b1, 1'b1, 10);
        check("illegal_err", 32'(err), 32'b10);
        check("illegal_count1", 32'(count[15:8]), 0);
        lvl(1, 1'b0, 1'b0, 10);
        clr = 1'b1;
        hold(1);
        clr = 1'b0;
        check("clr_err", 32'(err), 0);
        check("clr_all_count", 32'(count), 0);

        // Simultaneous steps on both channels.
        s0 = stp_tot[0];
        s1 = stp_tot[1];
        enc_a = 2'b11;
        hold(10);
        check("both_count", 32'(count), 32'h0101);
        check("both_steps", 32'((stp_tot[0] - s0) + (stp_tot[1] - s1)), 2);
        enc_a = 2'b00;
        hold(10);
        check("both_back", 32'(count), 0);

        // Short and long presses.
        sh = short_tot;
        lg = long_tot;
        btn_n = 1'b0; hold(10);
        btn_n = 1'b1; hold(15);
        check("short_pulse", 32'(short_tot - sh), 1);
        check("short_no_long", 32'(long_tot - lg), 0);
        sh = short_tot;
        lg = long_tot;
        btn_n = 1'b0; hold(40);
        btn_n = 1'b1; hold(15);
        check("long_pulse", 32'(long_tot - lg), 1);
        check("long_no_short", 32'(short_tot - sh), 0);

        // Reset mid-rotation with count0 = 3.
        lvl(0, 1'b1, 1'b0, 10); lvl(0, 1'b1, 1'b1, 10); lvl(0, 1'b0, 1'b1, 10);
        check("pre_rst_count0", 32'(count[7:0]), 3);
        lvl(0, 1'b0, 1'b0, 3);
        rst_n = 1'b0;
        hold(1);
        check("midrst_count", 32'(count), 0);
        check("midrst_dir", 32'(dir), 0);
        check("midrst_misc", 32'({step, err, btn_short, btn_long}), 0);
        rst_n = 1'b1;
        hold(12);
        check("post_rst_count", 32'(count), 0);

        // Disabled rotation leaves the count and emits no steps.
        lvl(0, 1'b1, 1'b0, 10);
        check("pre_ena_count0", 32'(count[7:0]), 1);
        s0 = stp_tot[0];
        ena = 1'b0;
        lvl(0, 1'b1, 1'b1, 10); lvl(0, 1'b0, 1'b1, 10);
        lvl(0, 1'b0, 1'b0, 10); lvl(0, 1'b1, 1'b0, 10);
        ena = 1'b1;
        hold(10);
        check("ena_count0", 32'(count[7:0]), 1);
        check("ena_steps", 32'(stp_tot[0] - s0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/quad_enc_multi.md
QUAD_ENC_MULTI -- requirements
Module: quad_enc_multi

Interface
REQ-001 Parameter N_CH, default 2: number of independent quadrature encoder channels.
REQ-002 Parameter CNT_W, default 8: per-channel position counter width.
REQ-003 Parameter DEB_CYC, default 4: consecutive stable synchronized samples required to accept a new input level.
REQ-004 Parameter LONG_CYC, default 16: debounced hold cycles defining a long press.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 ena  in  1  high = counting and event pulses enabled.
REQ-008 enc_a  in  N_CH  raw channel-A inputs, asynchronous.
REQ-009 enc_b  in  N_CH  raw channel-B inputs, asynchronous.
REQ-010 btn_n  in  1  raw pushbutton, active-low, asynchronous.
REQ-011 mode  in  2  resolution: 00 = x1, 01 = x2, 10/11 = x4; sampled every cycle.
REQ-012 wrap  in  1  1 = counters wrap modulo 2^CNT_W, 0 = counters saturate at 0 and 2^CNT_W-1.
REQ-013 clr  in  1  synchronous clear of all counts and error flags.
REQ-014 count  out  N_CH*CNT_W  channel i count at bits [i*CNT_W +: CNT_W], unsigned.
REQ-015 step  out  N_CH  one-cycle pulse per counted step.
REQ-016 dir  out  N_CH  direction of last counted step: 1 = CW, 0 = CCW.
REQ-017 err  out  N_CH  sticky illegal-transition flag.
REQ-018 btn_short  out  1  one-cycle pulse on release of a short press.
REQ-019 btn_long  out  1  one-cycle pulse when a press reaches LONG_CYC.

Function
REQ-020 Each raw input SHALL pass through a 2-flop synchronizer, then a debouncer.
REQ-021 Debouncer SHALL update its output only after the synchronized value differs from it for DEB_CYC consecutive cycles; any shorter glitch is ignored and restarts the count.
REQ-022 Debounced (A,B) CW sequence SHALL be 00->10->11->01->00; the reverse sequence is CCW.
REQ-023 x4: every legal transition SHALL count. x2: only legal transitions into 00 or 11 count. x1: only legal transitions into 00 count.
REQ-024 A counted CW step SHALL increment count by 1; a counted CCW step SHALL decrement it by 1.
REQ-025 A counted step SHALL assert step[i] for exactly one cycle and update dir[i] in that same cycle, whether or not saturation blocks the count change.
REQ-026 Latency: a raw level change held stable SHALL change count/step exactly 2+DEB_CYC+1 cycles after the first sampling edge (7 with defaults).
REQ-027 Saturation (wrap=0): increment at 2^CNT_W-1 and decrement at 0 SHALL leave count unchanged. Wrap (wrap=1): 2^CNT_W-1+1 -> 0 and 0-1 -> 2^CNT_W-1.
REQ-028 A debounced transition changing A and B together SHALL not count, SHALL set err[i], and SHALL update the previous-state register.
REQ-029 clr SHALL zero all counts and err in the next cycle, with priority over a same-cycle step; step pulses for that cycle are suppressed.
REQ-030 ena=0 SHALL freeze counts, suppress step/btn pulses and stop the press timer; synchronizers, debouncers and previous-state registers keep tracking, so no step is generated on re-enable.
REQ-031 Button FSM states: IDLE, PRESSED, LONG. IDLE->PRESSED on debounced press, timer cleared. PRESSED->LONG when timer reaches LONG_CYC, pulsing btn_long. PRESSED->IDLE on release, pulsing btn_short. LONG->IDLE on release, no pulse.
REQ-032 Channels SHALL be fully independent; simultaneous steps on several channels all count in the same cycle.

Reset
REQ-033 rst_n=0 at an edge SHALL clear count, step, dir, err, btn_short, btn_long to 0, the FSM to IDLE, debounce counters to 0, debounced encoders to 00 and the debounced button to released; reset is honoured mid-operation, pending transitions are discarded.

Verification
REQ-034 Defaults, x4, wrap=0: one CW cycle 00,10,11,01,00 on ch0, 10 cycles per level -> count0=4, dir0=1, four step0 pulses; count1=0.
REQ-035 x1 then x2: CW cycle x1 -> +1; CCW cycle x2 -> -2; from 0, wrap=0 -> count stays 0, dir=0, steps still pulse.
REQ-036 wrap=1, count=255, one CW x4 transition -> 0; 3-cycle glitch on enc_a -> no change.
REQ-037 ch1 00->11 directly -> err1=1, count1 unchanged; clr -> err1=0, all counts 0.
REQ-038 btn_n low 10 cycles -> btn_short once on release; low 40 cycles -> btn_long once, no btn_short on release.
REQ-039 rst_n low mid-rotation with count0=3 -> all outputs 0 next cycle; ena=0 during 4 CW transitions -> count unchanged after ena=1.
